// File: rtl/seq_divide.sv
// ---------------------------------------------------------------------------
// seq_divide
//   Sequential signed divider, one quotient bit per clock (restoring radix-2).
//   Recovers a QUOT_W-bit quotient and a DIVISOR_W-bit remainder from a
//   DIVIDEND_W-bit signed dividend (typically a product) and a signed divisor.
//   Division truncates toward zero; the remainder takes the dividend's sign.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operands valid          in_ready_o   operands accepted (IDLE)
//   dividend_i   signed dividend         divisor_i    signed divisor
//   out_valid_o  result valid            out_ready_i  consumer takes result
//   quot_o       low QUOT_W bits of the signed quotient
//   rem_o        signed remainder
//   exact_o      remainder zero, divisor non-zero
//   dbz_o        divisor was zero
//   ovf_o        full quotient does not fit in QUOT_W signed bits
// ---------------------------------------------------------------------------
module seq_divide #(
    parameter int DIVIDEND_W = 43,
    parameter int DIVISOR_W  = 18,
    parameter int QUOT_W     = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [QUOT_W-1:0]     quot_o,
    output logic [DIVISOR_W-1:0]  rem_o,
    output logic                  exact_o,
    output logic                  dbz_o,
    output logic                  ovf_o
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [DIVIDEND_W-1:0] r_dq;        // dividend bits shift out at the top, quotient bits in at the bottom
    logic [DIVISOR_W-1:0]  r_dvs_mag;
    logic [DIVISOR_W:0]    r_rem;       // partial remainder magnitude
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_dvd_neg;
    logic                  r_dvs_neg;
    logic                  r_dbz;
    logic                  r_out_valid;

    // Magnitudes of the incoming operands. The most negative value of each
    // negates to itself, which read as unsigned is exactly its magnitude.
    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dvs_mag;
    assign w_dvd_mag = dividend_i[DIVIDEND_W-1] ? -dividend_i : dividend_i;
    assign w_dvs_mag = divisor_i[DIVISOR_W-1]   ? -divisor_i  : divisor_i;

    // One restoring step: bring in the next dividend bit and trial-subtract.
    // The stored remainder is always below |divisor|, so its low DIVISOR_W
    // bits carry the full value before the shift.
    logic [DIVISOR_W:0]   w_shift;
    logic [DIVISOR_W+1:0] w_trial;
    logic                 w_fits;
    assign w_shift = {r_rem[DIVISOR_W-1:0], r_dq[DIVIDEND_W-1]};
    assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs_mag};
    assign w_fits  = ~w_trial[DIVISOR_W+1];

    // Sign correction. The full quotient needs one extra bit because
    // -2^(DIVIDEND_W-1) / -1 is positive 2^(DIVIDEND_W-1).
    logic [DIVIDEND_W:0]   w_qfull;
    logic [DIVISOR_W-1:0]  w_rem_s;
    logic [DIVIDEND_W-QUOT_W+1:0] w_q_upper;
    logic                  w_ovf;
    assign w_qfull   = (r_dvd_neg ^ r_dvs_neg) ? -{1'b0, r_dq} : {1'b0, r_dq};
    assign w_rem_s   = r_dvd_neg ? -r_rem[DIVISOR_W-1:0] : r_rem[DIVISOR_W-1:0];
    // Fits in QUOT_W signed only if every bit from QUOT_W-1 upward is a sign copy.
    assign w_q_upper = w_qfull[DIVIDEND_W:QUOT_W-1];
    assign w_ovf     = ~((&w_q_upper) | (~|w_q_upper));

    assign in_ready_o  = (r_state == S_IDLE) && !rst_i;
    assign out_valid_o = r_out_valid;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: only control state and outputs are reset; the datapath
            // registers are always loaded before they are read.
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            quot_o      <= '0;
            rem_o       <= '0;
            exact_o     <= 1'b0;
            dbz_o       <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_dq      <= w_dvd_mag;
                        r_dvs_mag <= w_dvs_mag;
                        r_dvd_neg <= dividend_i[DIVIDEND_W-1];
                        r_dvs_neg <= divisor_i[DIVISOR_W-1];
                        r_dbz     <= (divisor_i == '0);
                        r_rem     <= '0;
                        r_cnt     <= CNT_W'(DIVIDEND_W - 1);
                        r_state   <= S_CALC;
                    end
                end

                S_CALC: begin
                    if (r_dbz) begin
                        r_state <= S_FIX;
                    end else begin
                        r_rem <= w_fits ? w_trial[DIVISOR_W:0] : w_shift;
                        r_dq  <= {r_dq[DIVIDEND_W-2:0], w_fits};
                        if (r_cnt == '0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end

                S_FIX: begin
                    if (r_dbz) begin
                        quot_o  <= '0;
                        rem_o   <= '0;
                        exact_o <= 1'b0;
                        dbz_o   <= 1'b1;
                        ovf_o   <= 1'b0;
                    end else begin
                        quot_o  <= w_qfull[QUOT_W-1:0];
                        rem_o   <= w_rem_s;
                        exact_o <= (r_rem == '0);
                        dbz_o   <= 1'b0;
                        ovf_o   <= w_ovf;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divide.sv
// ---------------------------------------------------------------------------
// tb_seq_divide
//   Self-checking bench for seq_divide with default parameters. Expected
//   results are queued per operation (hand-written literals, the a*b/b
//   identity, or a truncating-division model in plain integer arithmetic)
//   and one compare process checks every cycle that out_valid_o is high.
// ---------------------------------------------------------------------------
module tb_seq_divide;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [42:0] dividend = '0;
    logic [17:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] quot;
    logic [17:0] rem;
    logic        exact, dbz, ovf;

    always #5 clk = ~clk;

    seq_divide dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quot_o      (quot),
        .rem_o       (rem),
        .exact_o     (exact),
        .dbz_o       (dbz),
        .ovf_o       (ovf)
    );

    typedef struct packed {
        logic [23:0] quot;
        logic [17:0] rem;
        logic        exact;
        logic        dbz;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input longint q, input longint r, input bit ex, input bit dz, input bit ov);
        exp_t e;
        e.quot  = q[23:0];
        e.rem   = r[17:0];
        e.exact = ex;
        e.dbz   = dz;
        e.ovf   = ov;
        return e;
    endfunction

    // Truncating signed division with plain integer arithmetic.
    function automatic exp_t model(input longint a, input longint b);
        longint q, r;
        if (b == 0) return mk(0, 0, 1'b0, 1'b1, 1'b0);
        q = a / b;
        r = a % b;
        return mk(q, r, r == 0, 1'b0, (q > 64'sd8388607) || (q < -64'sd8388608));
    endfunction

    // Compare process: every cycle a result is presented it must match the
    // oldest outstanding expectation; it retires on the output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q[0];
                check("quot",  quot,  e.quot);
                check("rem",   rem,   e.rem);
                check("exact", exact, e.exact);
                check("dbz",   dbz,   e.dbz);
                check("ovf",   ovf,   e.ovf);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic recover();
        exp_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    // Runs one operation; timing is measured from the accepting edge.
    // With stall > 0 the result is held under back-pressure while fresh
    // operands are offered, which must be ignored.
    task automatic run_op(input logic [42:0] dvd, input logic [17:0] dvs, input exp_t e, input int stall);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            recover();
            return;
        end
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_busy", in_ready, 64'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, (dvs == 18'd0) ? 64'd2 : 64'd44);
        if (!out_valid) begin
            recover();
            return;
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            dividend = 43'($urandom);
            divisor  = 18'd1;
            @(posedge clk); #1;
            check("stall_in_ready", in_ready, 64'd0);
            check("stall_out_valid", out_valid, 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_hs", in_ready, 64'd1);
        check("out_valid_after_hs", out_valid, 64'd0);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 64'd0);
        check("rst_out_valid", out_valid, 64'd0);
        check("rst_quot", quot, 64'd0);
        check("rst_rem", rem, 64'd0);
        check("rst_flags", {exact, dbz, ovf}, 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 64'd1);

        // Directed cases with hand-computed results.
        run_op(43'd1235678, 18'd2, mk(617839, 0, 1, 0, 0), 0);
        run_op(-43'sd7, 18'd2, mk(-3, -1, 0, 0, 0), 0);
        run_op(43'd7, -18'sd2, mk(-3, 1, 0, 0, 0), 0);
        run_op(-43'sd6, -18'sd3, mk(2, 0, 1, 0, 0), 0);
        run_op(43'd12345, 18'd0, mk(0, 0, 0, 1, 0), 0);
        run_op(43'h000_4000_0000, 18'd1, mk(0, 0, 1, 0, 1), 0);
        run_op(43'h400_0000_0000, 18'h3FFFF, mk(0, 0, 1, 0, 1), 0);
        run_op(43'd8388607, 18'd1, mk(8388607, 0, 1, 0, 0), 0);
        run_op(-43'sd8388608, 18'd1, mk(-8388608, 0, 1, 0, 0), 0);
        run_op(43'd1000, 18'h20000, mk(0, 1000, 0, 0, 0), 0);
        run_op(43'd100, 18'd7, mk(14, 2, 0, 0, 0), 10);
        // 2^30 + 7 over 2: quotient 2^29 + 3 (low bits 3, overflowing), rem 1.
        run_op(43'h000_4000_0007, 18'd2, mk(3, 1, 0, 0, 1), 0);

        // Reset in the middle of an operation: outputs from the previous
        // result must clear, and the aborted operation must never appear.
        dividend = 43'd1000000;
        divisor  = 18'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 64'd0);
        check("midrst_quot", quot, 64'd0);
        check("midrst_rem", rem, 64'd0);
        check("midrst_flags", {exact, dbz, ovf}, 64'd0);
        check("midrst_in_ready", in_ready, 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", in_ready, 64'd1);
        run_op(43'd100, 18'd7, mk(14, 2, 0, 0, 0), 0);

        // Products a*b divided by b must give back a exactly.
        for (int i = 0; i < 1000; i++) begin
            logic signed [23:0] a;
            logic signed [17:0] b;
            longint p;
            a = 24'($urandom);
            b = 18'($urandom);
            if ($urandom_range(0, 31) == 0) b = '0;
            p = longint'(a) * longint'(b);
            if (b == 0) run_op(p[42:0], b, mk(0, 0, 0, 1, 0), 0);
            else        run_op(p[42:0], b, mk(longint'(a), 0, 1, 0, 0), 0);
        end

        // Arbitrary operands of varied magnitude against the model.
        for (int i = 0; i < 100; i++) begin
            logic [63:0] t;
            logic [42:0] dv;
            logic [17:0] bv;
            t  = {$urandom, $urandom};
            t  = t >> $urandom_range(0, 42);
            dv = t[42:0];
            bv = 18'($urandom);
            bv = bv >> $urandom_range(0, 17);
            if ($urandom_range(0, 1) == 1) bv = -bv;
            run_op(dv, bv, model(longint'($signed(dv)), longint'($signed(bv))), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("all_results_seen", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
